mult_div_seq_unit: RTL and testbench

- Iterative 32x32 multiplier with HI/LO result registers.
- Sits in the EX stage beside the ALU. It consumes the mult_enable strobe and the rs/rt operands from the ID/EX pipeline register.
- Downstream, the HI/LO values are selected through sfmux_high and written back via sf2reg.
- Drives a stall so that mfhi/mflo and later multiplies wait for completion.

---
 rtl/mult_div_seq_unit.sv | 70 +++++++
 tb/tb_mult_div_seq_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq_unit.sv
// mult_div_seq_unit: iterative radix-2 shift-add 32x32 multiplier with HI/LO result registers and pipeline stall.
module mult_div_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mcand, res;
  logic [WIDTH-1:0] mplier, mag_a, mag_b;
  logic neg;
  always_comb begin
    mag_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
    res   = neg ? -acc : acc;
    busy  = state != IDLE;
    stall = busy;
  end
  // multiplicand shifts left and multiplier shifts right, so each RUN edge adds (mcand << cnt) when bit cnt is set
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand  <= {{WIDTH{1'b0}}, mag_a};
          mplier <= mag_b;
          neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= res;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_seq_unit.sv
// tb_mult_div_seq_unit: randomized and directed checks of mult_div_seq_unit against a plain-arithmetic product model.
module tb_mult_div_seq_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic signed_op = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy, stall, done;
  logic [31:0] hi, lo;
  int n_cmp = 0;
  int n_bad = 0;

  mult_div_seq_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  // Called at a negedge: drives the request, scrambles operands while busy, optionally pokes a
  // 9*9 start at run cycle poke, and returns at the negedge where done is observed.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int poke,
                       output logic [63:0] prod, output int lat, output int nstall, output logic stall_at_done);
    start = 1'b1; op_a = a; op_b = b; signed_op = s;
    @(negedge clk);
    lat = 0;
    nstall = 0;
    while (!done && lat < 100) begin
      if (stall) nstall++;
      start = (lat == poke);
      op_a = (lat == poke) ? 32'd9 : $urandom;
      op_b = (lat == poke) ? 32'd9 : $urandom;
      signed_op = 1'($urandom);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    prod = {hi, lo};
    stall_at_done = stall;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    if ({hi, lo, done, busy, stall} !== '0) begin
      $display("FAIL reset: hi=%h lo=%h done=%b busy=%b stall=%b, required all 0", hi, lo, done, busy, stall);
      n_bad++;
    end
    n_cmp++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_basic;
    logic [63:0] p; int lat, ns; logic sd;
    do_op(32'd7, 32'd6, 1'b0, -1, p, lat, ns, sd);
    if (p !== 64'h2A) begin $display("FAIL u7x6: got %h required %h", p, 64'h2A); n_bad++; end
    n_cmp++;
    if (lat !== 33) begin $display("FAIL u7x6_latency: got %0d required 33", lat); n_bad++; end
    n_cmp++;
    if (ns !== 33) begin $display("FAIL u7x6_stall_cycles: got %0d required 33", ns); n_bad++; end
    n_cmp++;
    if (sd !== 1'b0) begin $display("FAIL u7x6_stall_in_done: got %b required 0", sd); n_bad++; end
    n_cmp++;
    @(negedge clk);
    if (done !== 1'b0) begin $display("FAIL u7x6_done_width: got %b required 0", done); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_extremes;
    logic [31:0] ta [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tb [4] = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic ts [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] want [4] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001, 64'h40000000_00000000, 64'h1};
    logic [63:0] p; int lat, ns; logic sd;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], ts[i], -1, p, lat, ns, sd);
      if (p !== want[i]) begin
        $display("FAIL extreme%0d: %h*%h s=%b got %h required %h", i, ta[i], tb[i], ts[i], p, want[i]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_ignored_start;
    logic [63:0] p; int lat, ns; logic sd; int nd;
    do_op(32'd3, 32'd4, 1'b0, 9, p, lat, ns, sd);
    if (p !== 64'hC) begin $display("FAIL ignored_start_result: got %h required %h", p, 64'hC); n_bad++; end
    n_cmp++;
    if (lat !== 33 || ns !== 33) begin
      $display("FAIL ignored_start_busy: latency %0d stall %0d required 33/33", lat, ns);
      n_bad++;
    end
    n_cmp++;
    // back-to-back: start in the done cycle
    do_op(32'd2, 32'd2, 1'b0, -1, p, lat, ns, sd);
    if (p !== 64'h4 || lat !== 33) begin
      $display("FAIL back_to_back: got %h after %0d cycles required 4 after 33", p, lat);
      n_bad++;
    end
    n_cmp++;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    if (nd !== 0) begin $display("FAIL stray_done: got %0d pulses required 0", nd); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid;
    logic [63:0] p; int lat, ns; logic sd; int nd;
    do_op(32'd5, 32'd5, 1'b0, -1, p, lat, ns, sd);
    if (p !== 64'h19) begin $display("FAIL pre_reset_5x5: got %h required %h", p, 64'h19); n_bad++; end
    n_cmp++;
    start = 1'b1; op_a = 32'hFFFF; op_b = 32'hFFFF; signed_op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #2;
    if ({hi, lo} !== 64'h19 || busy !== 1'b1) begin
      $display("FAIL reset_async: hi=%h lo=%h busy=%b required 0/19/1", hi, lo, busy);
      n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b1;
    if ({hi, lo} !== 64'h0 || busy !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b stall=%b required 0/0/0/0", hi, lo, busy, stall);
      n_bad++;
    end
    n_cmp++;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || hi != 0 || lo != 0) nd++;
    end
    if (nd !== 0) begin $display("FAIL reset_mid_no_done: got %0d bad cycles required 0", nd); n_bad++; end
    n_cmp++;
    do_op(32'd2, 32'd3, 1'b0, -1, p, lat, ns, sd);
    if (p !== 64'h6) begin $display("FAIL post_reset_2x3: got %h required %h", p, 64'h6); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_random;
    logic [63:0] p, want; int lat, ns; logic sd; logic [31:0] a, b; logic s;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 5 == 0) a = 32'h80000000;
      if (i % 7 == 0) b = 32'h0;
      want = model(a, b, s);
      do_op(a, b, s, (i % 3 == 0) ? int'($urandom_range(0, 31)) : -1, p, lat, ns, sd);
      if (p !== want || lat !== 33) begin
        $display("FAIL random%0d: %h*%h s=%b got %h in %0d cycles required %h in 33", i, a, b, s, p, lat, want);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_basic;
    test_extremes;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
